// File: rtl/register_file_sweep.sv
// -----------------------------------------------------------------------------
// register_file_sweep
//
// Register file for the pipelined MIPS core, with DEPTH = 2**ADDR_WIDTH
// registers. It has two combinational read ports (decode) and one write port
// (write-back).
//   - Register 0 always reads zero, ignores writes and is never bypassed.
//   - Register SP_INDEX resets to SP_RST_VALUE. All other registers reset to 0.
//   - With BYPASS=1, same-cycle write data is forwarded to any matching read
//     port while the sweep FSM is IDLE.
//   - clear_i starts a sweep. The sweep rewrites registers 1..DEPTH-1 with
//     their reset values, one register per cycle, without asserting reset.
//
// Ports
//   clk                rising-edge clock
//   reset              asynchronous, active-low reset
//   reg_write_i        write enable
//   write_register_i   write address
//   write_data_i       write data
//   read_register_1_i  read port 1 address
//   read_register_2_i  read port 2 address
//   clear_i            request a clear sweep (sampled only in IDLE)
//   read_data_1_o      read port 1 data (combinational)
//   read_data_2_o      read port 2 data (combinational)
//   busy_o             registered, high while the sweep FSM is not IDLE
//   clear_done_o       registered, one-cycle pulse in the final sweep cycle
// -----------------------------------------------------------------------------
module register_file_sweep #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 5,
    parameter int          SP_INDEX     = 29,
    parameter logic [31:0] SP_RST_VALUE = 32'h1001_03FC,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_i,
    input  logic [ADDR_WIDTH-1:0] write_register_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [ADDR_WIDTH-1:0] read_register_1_i,
    input  logic [ADDR_WIDTH-1:0] read_register_2_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] read_data_1_o,
    output logic [DATA_WIDTH-1:0] read_data_2_o,
    output logic                  busy_o,
    output logic                  clear_done_o
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SP_RST    = DATA_WIDTH'(SP_RST_VALUE);
    localparam logic [ADDR_WIDTH-1:0] SP_IDX    = ADDR_WIDTH'(SP_INDEX);
    localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Value a register takes after reset or after the sweep visits it.
    function automatic logic [DATA_WIDTH-1:0] reset_value(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] val;
        if (idx == SP_IDX) begin
            val = SP_RST;
        end else begin
            val = DATA_ZERO;
        end
        return val;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    logic                  wr_we_s;     // committed write from write-back
    logic                  sweep_we_s;  // sweep rewrites reg[idx_q] this edge
    logic                  byp_en_s;    // write data may be forwarded to reads
    logic [DATA_WIDTH-1:0] rd1_s, rd2_s;

    // Sweep FSM next-state, index update and registered-output next values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_we_s    = 1'b0;
        sweep_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write on the same edge as clear_i still commits. The sweep
                // overwrites it later.
                if (reg_write_i && (write_register_i != ADDR_ZERO)) begin
                    wr_we_s = 1'b1;
                end else begin
                    wr_we_s = 1'b0;
                end
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = IDX_FIRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                sweep_we_s = 1'b1;
                if (idx_q == IDX_LAST) begin
                    // Park the index at 1 so it never wraps into register 0.
                    state_d = ST_DONE;
                    idx_d   = IDX_FIRST;
                end else begin
                    state_d = ST_CLEAR;
                    idx_d   = idx_q + IDX_FIRST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_FIRST;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Per-register next value: the sweep, a write, or hold. Register 0 stays zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                regs_d[i] = DATA_ZERO;
            end else if (sweep_we_s && (idx_q == ADDR_WIDTH'(i))) begin
                regs_d[i] = reset_value(idx_q);
            end else if (wr_we_s && (write_register_i == ADDR_WIDTH'(i))) begin
                regs_d[i] = write_data_i;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // State, index, registered status outputs and the register array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_value(ADDR_WIDTH'(i));
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // wr_we_s already excludes register 0 and non-IDLE states. That keeps
    // bypass off during a sweep and for register 0.
    assign byp_en_s = (BYPASS != 1'b0) && wr_we_s;

    // Read muxes: zero for register 0, forwarded write data, or array contents.
    always_comb begin
        if (read_register_1_i == ADDR_ZERO) begin
            rd1_s = DATA_ZERO;
        end else if (byp_en_s && (write_register_i == read_register_1_i)) begin
            rd1_s = write_data_i;
        end else begin
            rd1_s = regs_q[read_register_1_i];
        end
        if (read_register_2_i == ADDR_ZERO) begin
            rd2_s = DATA_ZERO;
        end else if (byp_en_s && (write_register_i == read_register_2_i)) begin
            rd2_s = write_data_i;
        end else begin
            rd2_s = regs_q[read_register_2_i];
        end
    end

    assign read_data_1_o = rd1_s;
    assign read_data_2_o = rd2_s;
    assign busy_o        = busy_q;
    assign clear_done_o  = done_q;

endmodule

// File: tb/tb_register_file_sweep.sv
// -----------------------------------------------------------------------------
// tb_register_file_sweep
//
// Two instances share all inputs: u_dut (BYPASS=1) and u_dut_nb (BYPASS=0).
// Stimulus is applied 1 ns after each rising edge. Each expectation is pushed
// with the cycle number it belongs to. A monitor on the falling edge pops and
// compares every expectation that is due.
// -----------------------------------------------------------------------------
module tb_register_file_sweep;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  write_register_i = 5'd0;
    logic [31:0] write_data_i = 32'd0;
    logic [4:0]  read_register_1_i = 5'd0;
    logic [4:0]  read_register_2_i = 5'd0;
    logic        clear_i = 1'b0;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, done_a, busy_b, done_b;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    int unsigned cyc_q [$];
    int          kind_q [$];
    logic [31:0] exp_q [$];
    string       nm_q [$];

    localparam logic [31:0] SP_VAL = 32'h1001_03FC;

    register_file_sweep #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset), .reg_write_i(reg_write_i),
        .write_register_i(write_register_i), .write_data_i(write_data_i),
        .read_register_1_i(read_register_1_i), .read_register_2_i(read_register_2_i),
        .clear_i(clear_i), .read_data_1_o(rd1_a), .read_data_2_o(rd2_a),
        .busy_o(busy_a), .clear_done_o(done_a)
    );

    register_file_sweep #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .reg_write_i(reg_write_i),
        .write_register_i(write_register_i), .write_data_i(write_data_i),
        .read_register_1_i(read_register_1_i), .read_register_2_i(read_register_2_i),
        .clear_i(clear_i), .read_data_1_o(rd1_b), .read_data_2_o(rd2_b),
        .busy_o(busy_b), .clear_done_o(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reset value of a register index.
    function automatic logic [31:0] rv(input int a);
        return (a == 29) ? SP_VAL : 32'd0;
    endfunction

    // kind: 0 rd1_a, 1 rd2_a, 2 busy_a, 3 done_a, 4 rd1_b, 5 rd2_b, 6 busy_b, 7 done_b
    task automatic expect_val(input int kind, input logic [31:0] v, input string nm);
        cyc_q.push_back(cyc);
        kind_q.push_back(kind);
        exp_q.push_back(v);
        nm_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write_i = 1'b1;
        write_register_i = a;
        write_data_i = d;
        tick();
        reg_write_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string nm);
        read_register_1_i = a1;
        read_register_2_i = a2;
        expect_val(0, e1, nm);
        expect_val(1, e2, nm);
        tick();
    endtask

    task automatic expect_status(input logic b, input logic d, input string nm);
        expect_val(2, {31'd0, b}, nm);
        expect_val(3, {31'd0, d}, nm);
    endtask

    // Monitor: compare every expectation that is due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
                int unsigned ec;
                int          k;
                logic [31:0] ev;
                logic [31:0] act;
                string       nm;
                ec = cyc_q.pop_front();
                k  = kind_q.pop_front();
                ev = exp_q.pop_front();
                nm = nm_q.pop_front();
                case (k)
                    0: act = rd1_a;
                    1: act = rd2_a;
                    2: act = {31'd0, busy_a};
                    3: act = {31'd0, done_a};
                    4: act = rd1_b;
                    5: act = rd2_b;
                    6: act = {31'd0, busy_b};
                    7: act = {31'd0, done_b};
                    default: act = 32'hXXXX_XXXX;
                endcase
                n_checks = n_checks + 1;
                if (ec != cyc) begin
                    $display("FAIL %s kind=%0d stale expectation for cycle %0d seen at %0d", nm, k, ec, cyc);
                end else if (act !== ev) begin
                    $display("FAIL %s kind=%0d cycle=%0d actual=%h required=%h", nm, k, cyc, act, ev);
                end else begin
                    n_pass = n_pass + 1;
                end
            end
        end
    end

    initial begin
        int budget;
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        expect_status(1'b0, 1'b0, "rst_status");
        reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a), rv(a), rv(31 - a), "rst_rd");
        end

        // ---------------- write then read ----------------
        wr(5'd8, 32'hDEAD_BEEF);
        rd(5'd8, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "wr_rd8");
        read_register_1_i = 5'd0;
        expect_val(0, 32'd0, "r0_no_bypass");
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 5'd0, 32'd0, 32'd0, "wr_r0");

        // ---------------- bypass ----------------
        wr(5'd9, 32'h0000_0001);
        wr(5'd10, 32'h0000_00A0);
        reg_write_i = 1'b1; write_register_i = 5'd9; write_data_i = 32'h55AA_55AA;
        read_register_1_i = 5'd9; read_register_2_i = 5'd10;
        expect_val(0, 32'h55AA_55AA, "byp_p1");
        expect_val(1, 32'h0000_00A0, "byp_p2_old");
        expect_val(4, 32'h0000_0001, "nobyp_p1");
        expect_val(5, 32'h0000_00A0, "nobyp_p2");
        tick();
        write_register_i = 5'd10; write_data_i = 32'h0BAD_F00D;
        expect_val(0, 32'h55AA_55AA, "byp_p1_arr");
        expect_val(1, 32'h0BAD_F00D, "byp_p2");
        expect_val(4, 32'h55AA_55AA, "nobyp_p1_arr");
        expect_val(5, 32'h0000_00A0, "nobyp_p2_old");
        tick();
        reg_write_i = 1'b0;
        rd(5'd10, 5'd9, 32'h0BAD_F00D, 32'h55AA_55AA, "byp_commit");

        // ---------------- clear sweep ----------------
        for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
        rd(5'd29, 5'd31, 32'd29, 32'd31, "preload");
        clear_i = 1'b1;
        reg_write_i = 1'b1; write_register_i = 5'd7; write_data_i = 32'h77;
        expect_status(1'b0, 1'b0, "pre_sweep");
        tick();
        clear_i = 1'b0;
        reg_write_i = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            expect_status(1'b1, (i == 32), "sweep_status");
            expect_val(6, 32'd1, "sweep_busy_nb");
            expect_val(7, {31'd0, (i == 32)}, "sweep_done_nb");
            if (i == 2) begin
                read_register_1_i = 5'd7;
                expect_val(0, 32'h77, "clr_wr_commit");
            end
            if (i == 5) begin
                reg_write_i = 1'b1; write_register_i = 5'd5; write_data_i = 32'h1234;
                read_register_1_i = 5'd5;
                expect_val(0, 32'd5, "busy_no_bypass");
            end
            if (i == 6) reg_write_i = 1'b0;
            if (i == 10) clear_i = 1'b1;
            if (i == 11) clear_i = 1'b0;
            if (i == 20) begin
                read_register_1_i = 5'd3; read_register_2_i = 5'd25;
                expect_val(0, 32'd0, "mid_cleared");
                expect_val(1, 32'd25, "mid_pending");
            end
            tick();
        end
        expect_status(1'b0, 1'b0, "post_sweep");
        tick();
        for (int a = 0; a < 32; a++) rd(5'(a), 5'(a), rv(a), rv(a), "after_clear");

        // ---------------- reset mid-sweep ----------------
        wr(5'd20, 32'h0000_ABCD);
        wr(5'd29, 32'h0000_0001);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 1; i < 10; i++) begin
            expect_status(1'b1, 1'b0, "sweep2_status");
            tick();
        end
        reset = 1'b0;
        expect_status(1'b0, 1'b0, "abort_now");
        tick();
        expect_status(1'b0, 1'b0, "abort_hold");
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_status(1'b0, 1'b0, "abort_no_done");
            tick();
        end
        for (int a = 0; a < 32; a++) rd(5'(a), 5'(a), rv(a), rv(a), "abort_rst_rd");
        wr(5'd3, 32'h0000_0007);
        rd(5'd3, 5'd3, 32'h7, 32'h7, "post_abort_wr");

        // Drain the scoreboard with a bounded wait.
        budget = 100;
        while (cyc_q.size() > 0 && budget > 0) begin
            tick();
            budget = budget - 1;
        end
        if (cyc_q.size() > 0) begin
            n_checks = n_checks + 1;
            $display("FAIL drain pending=%0d required=0", cyc_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
